// File: rtl/dram_cmd_pkg.sv
// Shared types and command encodings for the DRAM command scheduler.
//   dram_state_e : scheduler FSM states
//   dram_cmd_t   : pin-level command {csn, rasn, casn, wen[3:0]}
//   CMD_*        : NOP/PRE/ACT/RD encodings and the WR builder (byte enables)
//   max3         : helper used to size the shared wait counter
package dram_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ACT,
    ST_CAS,
    ST_WAIT,
    ST_RESP
  } dram_state_e;

  typedef struct packed {
    logic       csn;
    logic       rasn;
    logic       casn;
    logic [3:0] wen;
  } dram_cmd_t;

  localparam dram_cmd_t CMD_NOP = '{csn: 1'b1, rasn: 1'b1, casn: 1'b1, wen: 4'hF};
  localparam dram_cmd_t CMD_PRE = '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'h0};
  localparam dram_cmd_t CMD_ACT = '{csn: 1'b0, rasn: 1'b0, casn: 1'b1, wen: 4'hF};
  localparam dram_cmd_t CMD_RD  = '{csn: 1'b0, rasn: 1'b1, casn: 1'b0, wen: 4'hF};

  function automatic dram_cmd_t CMD_WR(input logic [3:0] wen);
    return '{csn: 1'b0, rasn: 1'b1, casn: 1'b0, wen: wen};
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dram_timer.sv
// Loadable down-counter shared by every timed wait in the scheduler.
//   dram_clk, dram_rstn : clock, async active-low reset
//   load, load_val      : load the counter this cycle
//   done                : counter has reached zero
// Loading T-1 on the edge that launches a command makes done high on the
// last cycle before the next command may be issued.
module dram_timer #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             dram_clk,
  input  logic             dram_rstn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge dram_clk or negedge dram_rstn) begin
    if (!dram_rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/dram_cmd_sched.sv
// Single-port DRAM command scheduler: turns one word read/write request at a
// time into timed PRE/ACT/RD/WR pin commands and returns one response.
//   dram_clk, dram_rstn          : clock, async active-low reset
//   req_valid/ready/write/addr/wdata/wstrb : request channel, addr = {row, col}
//   rsp_valid/ready/rdata        : response channel (rdata 0 for writes)
//   DRAM_CSn/RASn/CASn/WEn/A/D   : registered command pins
//   DRAM_Q, DRAM_VALID           : read data return
// Macro DRAM_CMD_SCHED_OPEN_PAGE_EN: defined keeps the row open between
// requests; undefined closes the row (PRE) after every access.
module dram_cmd_sched
  import dram_cmd_pkg::*;
#(
  parameter int unsigned ROW_W = 11,
  parameter int unsigned COL_W = 10,
  parameter int unsigned T_RP  = 5,
  parameter int unsigned T_RCD = 5,
  parameter int unsigned T_WR  = 5
) (
  input  logic                   dram_clk,
  input  logic                   dram_rstn,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [ROW_W+COL_W-1:0] req_addr,
  input  logic [31:0]            req_wdata,
  input  logic [3:0]             req_wstrb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_rdata,
  output logic                   DRAM_CSn,
  output logic                   DRAM_RASn,
  output logic                   DRAM_CASn,
  output logic [3:0]             DRAM_WEn,
  output logic [ROW_W-1:0]       DRAM_A,
  output logic [31:0]            DRAM_D,
  input  logic [31:0]            DRAM_Q,
  input  logic                   DRAM_VALID
);

  localparam int unsigned CNT_W = $clog2(max3(T_RP, T_RCD, T_WR) + 1);
  localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] WR_LD  = CNT_W'(T_WR - 1);

  dram_state_e state;
  dram_cmd_t   cmd_q;
  logic             row_open;
  logic [ROW_W-1:0] open_row;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             r_write;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  logic             accept;
  logic             hit;
  logic             wait_done;
  logic [ROW_W-1:0] src_row;
  logic [COL_W-1:0] src_col;
  logic             src_write;
  logic [31:0]      src_wdata;
  logic [3:0]       src_wstrb;

  // The first command is launched on the acceptance edge, so in IDLE the
  // command fields come straight from the request, later from the capture.
  always_comb begin
    if (state == ST_IDLE) begin
      src_row   = req_addr[ROW_W+COL_W-1:COL_W];
      src_col   = req_addr[COL_W-1:0];
      src_write = req_write;
      src_wdata = req_wdata;
      src_wstrb = req_wstrb;
    end else begin
      src_row   = r_row;
      src_col   = r_col;
      src_write = r_write;
      src_wdata = r_wdata;
      src_wstrb = r_wstrb;
    end
  end

  assign accept    = req_valid && req_ready;
  assign hit       = row_open && (src_row == open_row);
  assign wait_done = r_write ? tmr_done : DRAM_VALID;

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: if (accept && !hit) begin
        tmr_load = 1'b1;
        tmr_val  = row_open ? RP_LD : RCD_LD;
      end
      ST_PRE: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = RCD_LD;
      end
      ST_CAS: if (r_write) begin
        tmr_load = 1'b1;
        tmr_val  = WR_LD;
      end
`ifndef DRAM_CMD_SCHED_OPEN_PAGE_EN
      ST_WAIT: if (wait_done) begin
        tmr_load = 1'b1;
        tmr_val  = RP_LD;
      end
`endif
      default: ;
    endcase
  end

  dram_timer #(.CNT_W(CNT_W)) u_timer (
    .dram_clk  (dram_clk),
    .dram_rstn (dram_rstn),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .done      (tmr_done)
  );

  always_ff @(posedge dram_clk or negedge dram_rstn) begin
    if (!dram_rstn) begin
      state     <= ST_IDLE;
      cmd_q     <= CMD_NOP;
      row_open  <= 1'b0;
      open_row  <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      DRAM_A    <= '0;
      DRAM_D    <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      cmd_q <= CMD_NOP;
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      case (state)
        ST_IDLE: if (accept) begin
          r_row     <= src_row;
          r_col     <= src_col;
          r_write   <= src_write;
          r_wdata   <= src_wdata;
          r_wstrb   <= src_wstrb;
          req_ready <= 1'b0;
          if (hit) begin
            state  <= ST_CAS;
            cmd_q  <= src_write ? CMD_WR(~src_wstrb) : CMD_RD;
            DRAM_A <= ROW_W'(src_col);
            if (src_write) DRAM_D <= src_wdata;
          end else if (row_open) begin
            state    <= ST_PRE;
            cmd_q    <= CMD_PRE;
            DRAM_A   <= open_row;
            row_open <= 1'b0;
          end else begin
            state    <= ST_ACT;
            cmd_q    <= CMD_ACT;
            DRAM_A   <= src_row;
            row_open <= 1'b1;
            open_row <= src_row;
          end
        end
        ST_PRE: if (tmr_done) begin
          state    <= ST_ACT;
          cmd_q    <= CMD_ACT;
          DRAM_A   <= src_row;
          row_open <= 1'b1;
          open_row <= src_row;
        end
        ST_ACT: if (tmr_done) begin
          state  <= ST_CAS;
          cmd_q  <= src_write ? CMD_WR(~src_wstrb) : CMD_RD;
          DRAM_A <= ROW_W'(src_col);
          if (src_write) DRAM_D <= src_wdata;
        end
        ST_CAS: state <= ST_WAIT;
        ST_WAIT: if (wait_done) begin
          state     <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= r_write ? '0 : DRAM_Q;
`ifndef DRAM_CMD_SCHED_OPEN_PAGE_EN
          // Close-page: the precharge overlaps the response phase.
          cmd_q    <= CMD_PRE;
          DRAM_A   <= open_row;
          row_open <= 1'b0;
`endif
        end
        // Timer is idle (zero) here unless a close-page precharge is pacing.
        ST_RESP: if (tmr_done && (!rsp_valid || rsp_ready)) begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign DRAM_CSn  = cmd_q.csn;
  assign DRAM_RASn = cmd_q.rasn;
  assign DRAM_CASn = cmd_q.casn;
  assign DRAM_WEn  = cmd_q.wen;

endmodule

// File: tb/tb_dram_cmd_sched.sv
// Self-checking bench for dram_cmd_sched: directed and random transactions
// checked cycle by cycle against a timing model derived from the command rules.
module tb_dram_cmd_sched;

  localparam int ROW_W = 11;
  localparam int COL_W = 10;
  localparam int T_RP  = 5;
  localparam int T_RCD = 5;
  localparam int T_WR  = 5;
`ifdef DRAM_CMD_SCHED_OPEN_PAGE_EN
  localparam bit OPEN_PAGE = 1'b1;
`else
  localparam bit OPEN_PAGE = 1'b0;
`endif

  logic                   dram_clk;
  logic                   dram_rstn;
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [ROW_W+COL_W-1:0] req_addr;
  logic [31:0]            req_wdata;
  logic [3:0]             req_wstrb;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [31:0]            rsp_rdata;
  logic                   DRAM_CSn;
  logic                   DRAM_RASn;
  logic                   DRAM_CASn;
  logic [3:0]             DRAM_WEn;
  logic [ROW_W-1:0]       DRAM_A;
  logic [31:0]            DRAM_D;
  logic [31:0]            DRAM_Q;
  logic                   DRAM_VALID;

  dram_cmd_sched #(
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .T_RP  (T_RP),
    .T_RCD (T_RCD),
    .T_WR  (T_WR)
  ) dut (
    .dram_clk   (dram_clk),
    .dram_rstn  (dram_rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .DRAM_CSn   (DRAM_CSn),
    .DRAM_RASn  (DRAM_RASn),
    .DRAM_CASn  (DRAM_CASn),
    .DRAM_WEn   (DRAM_WEn),
    .DRAM_A     (DRAM_A),
    .DRAM_D     (DRAM_D),
    .DRAM_Q     (DRAM_Q),
    .DRAM_VALID (DRAM_VALID)
  );

  initial begin
    dram_clk = 1'b0;
    forever #5 dram_clk = ~dram_clk;
  end

  int cyc = 0;
  always @(posedge dram_clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int cur_t  = 0;

  // Reference state: which row the DRAM has open and what A/D last carried.
  bit         open_valid;
  logic [10:0] open_row;
  logic [10:0] last_a;
  logic [31:0] last_d;
  bit         pre_seen;
  int         last_pre;

  localparam logic [6:0] P_NOP = 7'b111_1111;
  localparam logic [6:0] P_PRE = 7'b001_0000;
  localparam logic [6:0] P_ACT = 7'b001_1111;
  localparam logic [6:0] P_RD  = 7'b010_1111;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, cur_t, obs, exp);
    end
  endtask

  task automatic model_reset();
    open_valid = 1'b0;
    open_row   = '0;
    last_a     = '0;
    last_d     = '0;
    pre_seen   = 1'b0;
    last_pre   = 0;
  endtask

  // One request from acceptance until req_ready returns (or an abort reset
  // two cycles after ACT).
  task automatic run_txn(input bit wr, input logic [20:0] addr, input logic [31:0] wd,
                         input logic [3:0] ws, input logic [31:0] rd, input int lat,
                         input int hold, input bit abort);
    int pre, act, cas, pre2, rsp, h, rdy, w, acc;
    logic [10:0] row, prev_row;
    logic [9:0]  col;
    logic [6:0]  exp_pins;
    row = addr[20:10];
    col = addr[9:0];
    prev_row = open_row;
    pre = -1; act = -1; pre2 = -1;
    if (open_valid && open_row == row) cas = 1;
    else if (open_valid) begin pre = 1; act = 1 + T_RP; cas = act + T_RCD; end
    else begin act = 1; cas = 1 + T_RCD; end
    rsp = wr ? cas + T_WR + 1 : cas + lat + 1;
    if (!OPEN_PAGE) pre2 = rsp;
    h = rsp + hold;
    if (OPEN_PAGE) rdy = h + 1;
    else rdy = (h + 1 > pre2 + T_RP) ? h + 1 : pre2 + T_RP;

    w = 0;
    while (req_ready !== 1'b1 && w < 50) begin @(negedge dram_clk); w++; end
    cur_t = 0;
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    acc = cyc;

    for (int t = 1; t <= rdy; t++) begin
      @(negedge dram_clk);
      cur_t = t;
      req_valid = 1'b0;
      req_write = 1'($urandom);
      req_addr  = 21'($urandom);
      req_wdata = $urandom;
      req_wstrb = 4'($urandom);
      // A stray VALID during the CAS cycle must be ignored.
      DRAM_VALID = (t == cas) || (!wr && t == cas + lat);
      DRAM_Q     = (t == cas) ? ~rd : (t == cas + lat) ? rd : $urandom;
      rsp_ready  = (t >= rsp + hold);
      if (abort && t == act + 2) begin
        dram_rstn = 1'b0;
        #1;
        chk("rst_pins", {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn}, P_NOP);
        chk("rst_a", DRAM_A, 11'h0);
        chk("rst_d", DRAM_D, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        @(negedge dram_clk);
        @(negedge dram_clk);
        DRAM_VALID = 1'b0;
        dram_rstn = 1'b1;
        model_reset();
        @(negedge dram_clk);
        chk("rst_req_ready", req_ready, 1'b1);
        return;
      end
      #1;
      exp_pins = P_NOP;
      if (t == pre || t == pre2) begin
        exp_pins = P_PRE;
        last_a = (t == pre) ? prev_row : row;
        pre_seen = 1'b1;
        last_pre = acc + t;
      end else if (t == act) begin
        exp_pins = P_ACT;
        last_a = row;
        if (pre_seen) chk("act_after_pre_gap", (acc + t - last_pre) >= T_RP, 1'b1);
      end else if (t == cas) begin
        exp_pins = wr ? {3'b010, ~ws} : P_RD;
        last_a = {1'b0, col};
        if (wr) last_d = wd;
      end
      chk("pins", {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn}, exp_pins);
      chk("dram_a", DRAM_A, last_a);
      chk("dram_d", DRAM_D, last_d);
      chk("rsp_valid", rsp_valid, (t >= rsp && t <= h));
      if (t >= rsp && t <= h) chk("rsp_rdata", rsp_rdata, wr ? 32'h0 : rd);
      chk("req_ready", req_ready, (t >= rdy));
    end
    DRAM_VALID = 1'b0;
    open_valid = OPEN_PAGE;
    open_row   = row;
  endtask

  bit          r_wr;
  logic [10:0] r_row;
  int unsigned r_sel;

  initial begin
    dram_rstn = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1'b1; DRAM_Q = '0; DRAM_VALID = 1'b0;
    model_reset();
    #2 dram_rstn = 1'b0;
    repeat (3) @(negedge dram_clk);
    chk("reset_pins", {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn}, P_NOP);
    chk("reset_a", DRAM_A, 11'h0);
    chk("reset_d", DRAM_D, 32'h0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    dram_rstn = 1'b1;
    @(negedge dram_clk);
    chk("reset_req_ready", req_ready, 1'b1);

    run_txn(1'b0, 21'h040000, 32'h0, 4'h0, 32'hFFFFFFFF, 3, 0, 1'b0);
    run_txn(1'b1, 21'h040001, 32'h12345678, 4'b0101, 32'h0, 1, 0, 1'b0);
    run_txn(1'b0, 21'h080000, 32'h0, 4'h0, 32'hA5A55A5A, 2, 0, 1'b0);
    run_txn(1'b0, 21'h080010, 32'h0, 4'h0, 32'hDEADBEEF, 1, 10, 1'b0);
    run_txn(1'b0, 21'h040002, 32'h0, 4'h0, 32'h0BADF00D, 1, 0, 1'b1);
    run_txn(1'b0, 21'h040002, 32'h0, 4'h0, 32'hC0FFEE11, 4, 0, 1'b0);
    run_txn(1'b0, 21'h040003, 32'h0, 4'h0, 32'h5555AAAA, 1, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      r_sel = $urandom_range(0, 2);
      r_row = (r_sel == 0) ? 11'h100 : (r_sel == 1) ? 11'h200 : 11'($urandom);
      r_wr  = 1'($urandom);
      run_txn(r_wr, {r_row, 10'($urandom)}, $urandom, 4'($urandom), $urandom,
              int'($urandom_range(1, 4)), int'($urandom_range(0, 3)), 1'b0);
    end

    repeat (2) @(negedge dram_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
